data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Memory-stage controller between the EX/MEM pipeline register and a variable-latency data memory. It converts a RV32I load or store into a word-aligned bus request with byte enables and lane-replicated write data, and stalls the pipeline until the memory responds. It returns the read word right-shifted so the addressed byte or half sits in bits [7:0] or [15:0], ready for the downstream load sign/zero-extension stage.

## Interface
Parameters:
- none; address and data are fixed at 32 bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `MemRead`  in  1  load in MEM stage.
- `MemWrite`  in  1  store in MEM stage. Wins if asserted together with `MemRead`.
- `funct3`  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address from ALU.
- `store_data`  in  32  rs2 value.
- `stall`  out  1  freeze IF/ID/EX/MEM registers.
- `misaligned`  out  1  one-cycle pulse: access rejected.
- `data_mem_out`  out  32  shifted load word, registered.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ready`=1.

## Operation
- Access types:
  - `access` = `MemRead|MemWrite`.
  - Width comes from `funct3[1:0]`: 00 byte, 01 half, other values word.
  - `off` = `addr[1:0]`.
- Misaligned access: half with `off[0]`=1, or word with `off`≠0.
  - No bus request is issued and `stall` stays 0.
  - `misaligned`=1 for exactly that cycle.
  - `data_mem_out` is unchanged.
- Byte enables:
  - SB: `4'b0001<<off`.
  - SH: `4'b0011<<off`.
  - SW: `4'b1111`.
  - Loads: always `4'b1111`.
- Write data:
  - SB: `{4{store_data[7:0]}}`.
  - SH: `{2{store_data[15:0]}}`.
  - SW: `store_data`.
- Load result: `data_mem_out` ← `mem_rdata >> (8*off)`, zero-filled in the upper bits.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE:
    - Aligned `access`: `stall`=1 combinationally. At the clock edge, register `mem_addr`, `mem_be`, `mem_wdata`, `mem_we`, set `mem_req`=1, and go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - `stall`=1 and `mem_req` is held at 1.
    - Bus outputs stay stable until `mem_ready`.
    - On `mem_ready`: clear `mem_req`, capture `data_mem_out` (loads only), and go to DONE.
  - DONE:
    - `stall`=0 and no request is issued, so the pipeline advances past the instruction just serviced.
    - Next state is IDLE.
- `mem_ready` in IDLE or DONE is ignored.
- Reset:
  - Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `data_mem_out`=0, `misaligned`=0.
  - `stall`=0 while `rst` is high.
  - Reset in BUSY abandons the transaction. A late `mem_ready` after reset is ignored.

## Timing
- `mem_req` rises 1 cycle after the first cycle `access` is seen.
- Total stall = 1 + N cycles, where N ≥ 1 is the number of cycles `mem_req` is high up to and including the `mem_ready` cycle.
- Zero-wait memory (`mem_ready` on the first request cycle): stall is 2 cycles, and DONE is the 3rd cycle of the instruction.
- `data_mem_out` is valid from the DONE cycle and holds until the next load completes.
- `misaligned` is registered: it pulses the cycle after detection, and that is the same cycle the pipeline has advanced.

## Structure
- Shared package `mem_pkg` holds:
  - FSM state enum (IDLE/BUSY/DONE).
  - funct3 constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Width codes.
- Sub-module `mem_lane_align` is purely combinational. It takes `funct3`, `off`, `store_data` and `is_store`, and produces `be`, `wdata` and `misaligned`.
- The FSM, registers and read shifter live in the top module.

## Test plan
- Zero-wait SW: `addr`=0x1004, `store_data`=0xDEADBEEF, `mem_ready` tied 1.
  - `mem_addr`=0x1004, `mem_be`=1111, `mem_wdata`=0xDEADBEEF, `mem_we`=1.
  - `stall` high for 2 cycles; DONE on the 3rd cycle.
- SB with offset: `addr`=0x2003, `store_data`=0x000000A5.
  - `mem_addr`=0x2000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- LH with wait states: `addr`=0x3002, `mem_rdata`=0x8001_1234, `mem_ready` after 3 request cycles.
  - `stall` high for 4 cycles.
  - `data_mem_out`=0x0000_8001 in DONE.
- Misaligned LW: `addr`=0x4001.
  - `mem_req` never rises and `stall`=0.
  - `misaligned` pulses 1 cycle; `data_mem_out` is unchanged.
- Reset in BUSY: assert `rst` for 1 cycle, then drive `mem_ready`=1.
  - State returns to IDLE and `mem_req`=0 after the edge.
  - The late `mem_ready` does not change `data_mem_out` (stays 0).
- Back-to-back: LBU at 0x5001 immediately followed by SH at 0x5002.
  - The two requests are separated by DONE and IDLE cycles.
  - Second request has `mem_be`=1100.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage controller.
// Holds the FSM state enum, RV32I load/store funct3 codes and access width decoding.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        WID_BYTE = 2'b00,
        WID_HALF = 2'b01,
        WID_WORD = 2'b10
    } width_e;

    // Signedness lives in funct3[2] and is handled downstream, so only the low bits matter here.
    function automatic width_e widthOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return WID_BYTE;
            2'b01:   return WID_HALF;
            default: return WID_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for one access: byte enables, replicated store data
// and the alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic        is_store_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    width_e wid;

    assign wid = widthOf(funct3_i);

    // Loads always fetch the whole word; only stores narrow the enables.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (wid)
            WID_BYTE: begin
                if (is_store_i) begin
                    be_o    = 4'b0001 << off_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
            end
            WID_HALF: begin
                misaligned_o = off_i[0];
                if (is_store_i) begin
                    be_o    = 4'b0011 << off_i;
                    wdata_o = {2{store_data_i[15:0]}};
                end
            end
            default: begin
                misaligned_o = |off_i;
                if (is_store_i) begin
                    wdata_o = store_data_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage controller: turns a load/store into a word-aligned bus request, stalls
// the pipeline until the memory answers, and returns the load word shifted down.
module data_mem_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] data_mem_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] data_q;
    logic        misaligned_q;
    logic [1:0]  off_q;

    logic        access;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        mis_d;
    logic        start_d;
    logic [31:0] load_d;

    assign access = MemRead | MemWrite;

    mem_lane_align u_align (
        .funct3_i     (funct3),
        .off_i        (addr[1:0]),
        .store_data_i (store_data),
        .is_store_i   (MemWrite),
        .be_o         (be_d),
        .wdata_o      (wdata_d),
        .misaligned_o (mis_d)
    );

    assign start_d = (state_q == IDLE) && access && !mis_d;
    assign load_d  = mem_rdata >> {off_q, 3'b000};

    // The byte offset is kept because mem_addr drops it and the pipeline may move on after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            data_q       <= 32'h0;
            misaligned_q <= 1'b0;
            off_q        <= 2'b00;
        end else begin
            misaligned_q <= (state_q == IDLE) && access && mis_d;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        mem_addr_q  <= {addr[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= MemWrite;
                        off_q       <= addr[1:0];
                        mem_req_q   <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            data_q <= load_d;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // The first cycle of an access stalls before any register has seen it.
    assign stall = !rst && (start_d || (state_q == BUSY));

    assign misaligned   = misaligned_q;
    assign data_mem_out = data_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios followed by random
// loads/stores against a byte-level reference model with a variable-latency responder.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        misaligned;
    logic [31:0] data_mem_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int total;
    int bad;
    logic [31:0] expOut;

    data_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .data_mem_out (data_mem_out),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int nBytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] modelBe(input logic isStore, input logic [2:0] f3, input logic [1:0] off);
        int mask;
        if (!isStore) return 4'hF;
        mask = ((1 << nBytes(f3)) - 1) << off;
        return mask[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int n;
        n = nBytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic idleCycle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        checkOutput("idleStall", stall, 1'b0);
        checkOutput("idleReq", mem_req, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Drives one MEM-stage instruction and plays the memory with the given latency.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input int lat, input logic [31:0] rdata);
        logic [1:0] off;
        logic       isMis;
        logic       isLoad;
        int         cyc;
        int         stallCnt;
        int         reqCnt;
        logic       done;
        off    = a[1:0];
        isMis  = (int'(off) % nBytes(f3)) != 0;
        isLoad = rd && !wr;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        mem_rdata  = rdata;
        mem_ready  = 1'b0;
        if (isMis) begin
            @(negedge clk);
            checkOutput("misStall", stall, 1'b0);
            checkOutput("misReq", mem_req, 1'b0);
            checkOutput("misEarly", misaligned, 1'b0);
            @(posedge clk);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            @(negedge clk);
            checkOutput("misPulse", misaligned, 1'b1);
            checkOutput("misReqAfter", mem_req, 1'b0);
            checkOutput("misData", data_mem_out, expOut);
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("misDrop", misaligned, 1'b0);
            @(posedge clk);
            #1;
        end else begin
            cyc      = 0;
            stallCnt = 0;
            reqCnt   = 0;
            done     = 1'b0;
            while (!done && cyc < 100) begin
                @(negedge clk);
                if (cyc == 0) begin
                    checkOutput("firstReq", mem_req, 1'b0);
                    checkOutput("firstMis", misaligned, 1'b0);
                end
                if (stall) stallCnt++;
                if (mem_req) begin
                    reqCnt++;
                    checkOutput("busAddr", mem_addr, {a[31:2], 2'b00});
                    checkOutput("busBe", mem_be, modelBe(wr, f3, off));
                    checkOutput("busWe", mem_we, wr);
                    if (wr) checkOutput("busWdata", mem_wdata, modelWdata(f3, sd));
                    if (reqCnt == lat) begin
                        mem_ready = 1'b1;
                        if (isLoad) expOut = rdata >> (8 * int'(off));
                    end
                end else if (cyc > 0) begin
                    done = 1'b1;
                    checkOutput("stallCycles", stallCnt, 1 + lat);
                    checkOutput("doneStall", stall, 1'b0);
                    checkOutput("loadData", data_mem_out, expOut);
                end
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                if (done) begin
                    MemRead  = 1'b0;
                    MemWrite = 1'b0;
                end
                cyc++;
            end
            if (!done) checkOutput("timeout", 32'd1, 32'd0);
        end
    endtask

    initial begin
        logic [2:0] f3Tab [5];
        logic       rdR;
        logic       wrR;
        total      = 0;
        bad        = 0;
        expOut     = 32'h0;
        clk        = 1'b0;
        rst        = 1'b1;
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0000_1000;
        store_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        f3Tab[0] = 3'b000;
        f3Tab[1] = 3'b001;
        f3Tab[2] = 3'b010;
        f3Tab[3] = 3'b100;
        f3Tab[4] = 3'b101;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstStall", stall, 1'b0);
        checkOutput("rstReq", mem_req, 1'b0);
        checkOutput("rstWe", mem_we, 1'b0);
        checkOutput("rstAddr", mem_addr, 32'h0);
        checkOutput("rstBe", mem_be, 4'h0);
        checkOutput("rstWdata", mem_wdata, 32'h0);
        checkOutput("rstData", data_mem_out, 32'h0);
        checkOutput("rstMis", misaligned, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        MemRead = 1'b0;
        idleCycle();

        applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 2, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0, 3, 32'h8001_1234);
        checkOutput("lhResult", data_mem_out, 32'h0000_8001);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0, 1, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_5001, 32'h0, 1, 32'h1122_3344);
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 2, 32'h0);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_5008, 32'h1357_9BDF, 1, 32'hFFFF_FFFF);

        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0000_6000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        checkOutput("busyRstStall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        expOut    = 32'h0;
        @(negedge clk);
        checkOutput("busyRstReq", mem_req, 1'b0);
        checkOutput("busyRstStall2", stall, 1'b0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("lateReadyData", data_mem_out, 32'h0);
        checkOutput("lateReadyReq", mem_req, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            rdR = 1'($urandom_range(0, 1));
            wrR = 1'($urandom_range(0, 1));
            if (!rdR && !wrR) rdR = 1'b1;
            applyStimulus(rdR, wrR, f3Tab[$urandom_range(0, 4)], $urandom, $urandom,
                          int'($urandom_range(1, 4)), $urandom);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
